uart_rx_ovs: RTL and testbench

UART_RX_OVS -- requirements
Module: uart_rx_ovs

---
 rtl/uart_rx_ovs_pkg.sv | 16 +
 rtl/uart_rx_ovs_sync_2ff.sv | 22 ++
 rtl/uart_rx_ovs.sv | 116 +++++++++++
 tb/tb_uart_rx_ovs.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_rx_ovs_pkg.sv
// Shared UART definitions: FSM state encoding and default frame geometry.
// Imported by the receiver and intended for reuse by the transmitter.
package uart_rx_ovs_pkg;

    localparam int OVERSAMPLE_DEF = 16;
    localparam int DATA_BITS_DEF  = 8;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_DATA      = 3'd2,
        ST_STOP      = 3'd3,
        ST_WAIT_HIGH = 3'd4
    } uart_state_t;

endpackage

// File: rtl/uart_rx_ovs_sync_2ff.sv
// Two-flop synchronizer for one asynchronous bit.
// Resets to 1 so an idle-high line never looks like a start bit.
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= 1'b1;
            q    <= 1'b1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx_ovs.sv
// Oversampling UART receiver: mid-bit sampling driven by an external tick.
// Start bit is re-checked at its midpoint to reject line glitches.
module uart_rx_ovs
    import uart_rx_ovs_pkg::*;
#(
    parameter int OVERSAMPLE = OVERSAMPLE_DEF,
    parameter int DATA_BITS  = DATA_BITS_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 tick,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_done,
    output logic                 rx_busy,
    output logic                 frame_err
);

    localparam int CW = $clog2(OVERSAMPLE);
    localparam int IW = $clog2(DATA_BITS);

    localparam logic [CW-1:0] CNT_HALF = CW'(OVERSAMPLE / 2 - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(OVERSAMPLE - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(DATA_BITS - 1);

    uart_state_t          state;
    logic [CW-1:0]        cnt;
    logic [IW-1:0]        idx;
    logic [DATA_BITS-1:0] shreg;
    logic                 rx_s;

    sync_2ff u_sync (
        .clk(clk),
        .rst(rst),
        .d  (rx),
        .q  (rx_s)
    );

    assign rx_busy = (state != ST_IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            idx       <= '0;
            shreg     <= '0;
            rx_data   <= '0;
            rx_done   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            rx_done   <= 1'b0;
            frame_err <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (!rx_s) begin
                        state <= ST_START;
                        cnt   <= '0;
                    end
                end
                ST_START: begin
                    if (tick) begin
                        if (cnt == CNT_HALF) begin
                            cnt   <= '0;
                            idx   <= '0;
                            state <= rx_s ? ST_IDLE : ST_DATA;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                ST_DATA: begin
                    if (tick) begin
                        if (cnt == CNT_LAST) begin
                            cnt   <= '0;
                            shreg <= {rx_s, shreg[DATA_BITS-1:1]};
                            if (idx == IDX_LAST) begin
                                state <= ST_STOP;
                            end else begin
                                idx <= idx + 1'b1;
                            end
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                ST_STOP: begin
                    if (tick) begin
                        if (cnt == CNT_LAST) begin
                            cnt <= '0;
                            if (rx_s) begin
                                rx_data <= shreg;
                                rx_done <= 1'b1;
                                state   <= ST_IDLE;
                            end else begin
                                frame_err <= 1'b1;
                                state     <= ST_WAIT_HIGH;
                            end
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                ST_WAIT_HIGH: begin
                    // A held-low line (break) stays here so it reports only once.
                    if (rx_s) begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_ovs.sv
// Self-checking bench for uart_rx_ovs: directed scenarios plus random frames
// compared against an ideal byte-stream model.
module tb_uart_rx_ovs;

    localparam int OVS     = 16;
    localparam int DB      = 8;
    localparam int TDIV    = 4;
    localparam int BIT_CLK = OVS * TDIV;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          tick = 1'b0;
    logic          rx = 1'b1;
    logic [DB-1:0] rx_data;
    logic          rx_done;
    logic          rx_busy;
    logic          frame_err;

    int checks = 0;
    int failures = 0;

    logic [7:0] done_q[$];
    int         ferr_cnt = 0;
    int         both_cnt = 0;
    int         tcnt = 0;
    logic [7:0] last_good = 8'h00;

    uart_rx_ovs #(
        .OVERSAMPLE(OVS),
        .DATA_BITS (DB)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .tick     (tick),
        .rx       (rx),
        .rx_data  (rx_data),
        .rx_done  (rx_done),
        .rx_busy  (rx_busy),
        .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    // Upstream baud generator: one-clk tick every TDIV clocks
    always @(negedge clk) begin
        tcnt <= (tcnt == TDIV - 1) ? 0 : tcnt + 1;
        tick <= (tcnt == TDIV - 1);
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (rx_done) done_q.push_back(rx_data);
            if (frame_err) ferr_cnt <= ferr_cnt + 1;
            if (rx_done && frame_err) both_cnt <= both_cnt + 1;
        end
    end

    task automatic hold(input logic v, input int n);
        rx = v;
        repeat (n) @(negedge clk);
    endtask

    task automatic send(input logic [7:0] b, input int bc, input logic stop);
        hold(1'b0, bc);
        for (int i = 0; i < DB; i++) hold(b[i], bc);
        hold(stop, bc);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        rx = 1'b1;
        repeat (4) @(negedge clk);
        checks += 4;
        if (rx_data !== 8'h00) begin
            failures++;
            $display("FAIL reset_data got=%h exp=00", rx_data);
        end
        if (rx_done !== 1'b0) begin
            failures++;
            $display("FAIL reset_done got=%b exp=0", rx_done);
        end
        if (frame_err !== 1'b0) begin
            failures++;
            $display("FAIL reset_ferr got=%b exp=0", frame_err);
        end
        if (rx_busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_busy got=%b exp=0", rx_busy);
        end
        rst = 1'b0;
        hold(1'b1, 2 * BIT_CLK);
    endtask

    task automatic test_single;
        int q0 = done_q.size();
        int f0 = ferr_cnt;
        send(8'hA5, BIT_CLK, 1'b1);
        hold(1'b1, 2 * BIT_CLK);
        last_good = 8'hA5;
        checks += 4;
        if (done_q.size() - q0 !== 1) begin
            failures++;
            $display("FAIL a5_count got=%0d exp=1", done_q.size() - q0);
        end else if (done_q[q0] !== 8'hA5) begin
            failures++;
            $display("FAIL a5_data got=%h exp=a5", done_q[q0]);
        end
        if (ferr_cnt - f0 !== 0) begin
            failures++;
            $display("FAIL a5_ferr got=%0d exp=0", ferr_cnt - f0);
        end
        if (rx_busy !== 1'b0) begin
            failures++;
            $display("FAIL a5_busy got=%b exp=0", rx_busy);
        end
        if (rx_data !== 8'hA5) begin
            failures++;
            $display("FAIL a5_hold got=%h exp=a5", rx_data);
        end
    endtask

    task automatic test_back_to_back;
        int q0 = done_q.size();
        send(8'h00, BIT_CLK, 1'b1);
        send(8'hFF, BIT_CLK, 1'b1);
        hold(1'b1, 2 * BIT_CLK);
        last_good = 8'hFF;
        checks++;
        if (done_q.size() - q0 !== 2) begin
            failures++;
            $display("FAIL b2b_count got=%0d exp=2", done_q.size() - q0);
        end else begin
            checks += 2;
            if (done_q[q0] !== 8'h00) begin
                failures++;
                $display("FAIL b2b_first got=%h exp=00", done_q[q0]);
            end
            if (done_q[q0+1] !== 8'hFF) begin
                failures++;
                $display("FAIL b2b_second got=%h exp=ff", done_q[q0+1]);
            end
        end
    endtask

    task automatic test_glitch;
        int q0 = done_q.size();
        int f0 = ferr_cnt;
        bit seen = 0;
        hold(1'b0, 3 * TDIV);
        rx = 1'b1;
        for (int i = 0; i < BIT_CLK; i++) begin
            @(negedge clk);
            if (rx_busy) seen = 1;
        end
        hold(1'b1, BIT_CLK);
        checks += 4;
        if (!seen) begin
            failures++;
            $display("FAIL glitch_busy_seen got=0 exp=1");
        end
        if (rx_busy !== 1'b0) begin
            failures++;
            $display("FAIL glitch_busy_end got=%b exp=0", rx_busy);
        end
        if (done_q.size() - q0 !== 0) begin
            failures++;
            $display("FAIL glitch_done got=%0d exp=0", done_q.size() - q0);
        end
        if (ferr_cnt - f0 !== 0) begin
            failures++;
            $display("FAIL glitch_ferr got=%0d exp=0", ferr_cnt - f0);
        end
    endtask

    task automatic test_frame_err;
        int q0 = done_q.size();
        int f0 = ferr_cnt;
        logic [7:0] b = 8'($urandom);
        send(8'h3C, BIT_CLK, 1'b0);
        hold(1'b0, 3 * BIT_CLK);
        checks += 3;
        if (ferr_cnt - f0 !== 1) begin
            failures++;
            $display("FAIL ferr_count got=%0d exp=1", ferr_cnt - f0);
        end
        if (done_q.size() - q0 !== 0) begin
            failures++;
            $display("FAIL ferr_done got=%0d exp=0", done_q.size() - q0);
        end
        if (rx_data !== last_good) begin
            failures++;
            $display("FAIL ferr_data got=%h exp=%h", rx_data, last_good);
        end
        hold(1'b1, 2 * BIT_CLK);
        send(b, BIT_CLK, 1'b1);
        hold(1'b1, 2 * BIT_CLK);
        last_good = b;
        checks += 2;
        if (done_q.size() - q0 !== 1) begin
            failures++;
            $display("FAIL ferr_recover got=%0d exp=1", done_q.size() - q0);
        end else if (done_q[q0] !== b) begin
            failures++;
            $display("FAIL ferr_next got=%h exp=%h", done_q[q0], b);
        end
        if (ferr_cnt - f0 !== 1) begin
            failures++;
            $display("FAIL ferr_total got=%0d exp=1", ferr_cnt - f0);
        end
    endtask

    task automatic test_reset_midframe;
        int q0;
        logic [7:0] b = 8'h5A;
        hold(1'b0, BIT_CLK);
        for (int i = 0; i < 4; i++) hold(b[i], BIT_CLK);
        hold(b[4], BIT_CLK / 2);
        checks++;
        if (rx_busy !== 1'b1) begin
            failures++;
            $display("FAIL mid_busy got=%b exp=1", rx_busy);
        end
        #2 rst = 1'b1;
        #1;
        checks += 4;
        if (rx_data !== 8'h00) begin
            failures++;
            $display("FAIL mid_rst_data got=%h exp=00", rx_data);
        end
        if (rx_done !== 1'b0) begin
            failures++;
            $display("FAIL mid_rst_done got=%b exp=0", rx_done);
        end
        if (frame_err !== 1'b0) begin
            failures++;
            $display("FAIL mid_rst_ferr got=%b exp=0", frame_err);
        end
        if (rx_busy !== 1'b0) begin
            failures++;
            $display("FAIL mid_rst_busy got=%b exp=0", rx_busy);
        end
        rx = 1'b1;
        repeat (8) @(negedge clk);
        rst = 1'b0;
        q0 = done_q.size();
        hold(1'b1, 2 * BIT_CLK);
        send(8'h81, BIT_CLK, 1'b1);
        hold(1'b1, 2 * BIT_CLK);
        last_good = 8'h81;
        checks++;
        if (done_q.size() - q0 !== 1) begin
            failures++;
            $display("FAIL mid_count got=%0d exp=1", done_q.size() - q0);
        end else begin
            checks++;
            if (done_q[q0] !== 8'h81) begin
                failures++;
                $display("FAIL mid_data got=%h exp=81", done_q[q0]);
            end
        end
    endtask

    task automatic test_skew;
        int bcs[2] = '{BIT_CLK - 2, BIT_CLK + 2};
        for (int k = 0; k < 2; k++) begin
            int q0 = done_q.size();
            send(8'h55, bcs[k], 1'b1);
            hold(1'b1, 2 * BIT_CLK);
            checks++;
            if (done_q.size() - q0 !== 1) begin
                failures++;
                $display("FAIL skew%0d_count got=%0d exp=1",
                         bcs[k], done_q.size() - q0);
            end else begin
                checks++;
                if (done_q[q0] !== 8'h55) begin
                    failures++;
                    $display("FAIL skew%0d_data got=%h exp=55",
                             bcs[k], done_q[q0]);
                end
            end
        end
        last_good = 8'h55;
    endtask

    task automatic test_random;
        logic [7:0] exp_q[$];
        int q0 = done_q.size();
        int f0 = ferr_cnt;
        for (int n = 0; n < 16; n++) begin
            logic [7:0] b = 8'($urandom);
            int bc = BIT_CLK - 2 + int'($urandom_range(0, 4));
            exp_q.push_back(b);
            send(b, bc, 1'b1);
            hold(1'b1, int'($urandom_range(0, 2)) * BIT_CLK);
        end
        hold(1'b1, 2 * BIT_CLK);
        checks += 2;
        if (ferr_cnt - f0 !== 0) begin
            failures++;
            $display("FAIL rand_ferr got=%0d exp=0", ferr_cnt - f0);
        end
        if (done_q.size() - q0 !== exp_q.size()) begin
            failures++;
            $display("FAIL rand_count got=%0d exp=%0d",
                     done_q.size() - q0, exp_q.size());
        end else begin
            foreach (exp_q[i]) begin
                checks++;
                if (done_q[q0+i] !== exp_q[i]) begin
                    failures++;
                    $display("FAIL rand_data%0d got=%h exp=%h",
                             i, done_q[q0+i], exp_q[i]);
                end
            end
        end
    endtask

    task automatic test_exclusive;
        checks++;
        if (both_cnt !== 0) begin
            failures++;
            $display("FAIL done_ferr_overlap got=%0d exp=0", both_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_glitch();
        test_frame_err();
        test_reset_midframe();
        test_skew();
        test_random();
        test_exclusive();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
